// File: rtl/block_offset_issuer.sv
// block_offset_issuer: walks a DIM-dimensional block grid, issuing one offset per handshake.
// Define BOFS_ISLAST_EN to add o_islast, flagging the final offset of each sequence.
module block_offset_issuer #(
  parameter int DIM = 2,
  parameter int BW  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              cfg_rdy,
  output logic              cfg_ack,
  input  logic [DIM*BW-1:0] i_bboundary,
  input  logic [DIM*BW-1:0] i_bshape,
  output logic              dst_bofs_rdy,
  input  logic              dst_bofs_ack,
  output logic [DIM*BW-1:0] o_bofs
`ifdef BOFS_ISLAST_EN
  ,
  output logic              o_islast
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [DIM*BW-1:0] bnd, shp, ofs, ofs_n, shp_in;
  logic [BW:0] sum;
  logic zero_bnd, carry, c_in;
  always_comb begin
    zero_bnd = 1'b0;
    shp_in = i_bshape;
    for (int d = 0; d < DIM; d++) begin
      zero_bnd = zero_bnd | (i_bboundary[d*BW +: BW] == '0);
      shp_in[d*BW +: BW] = (i_bshape[d*BW +: BW] == '0) ? BW'(1) : i_bshape[d*BW +: BW];
    end
  end
  // Ripple from the innermost dimension; a final carry-out means this was the last offset.
  always_comb begin
    carry = 1'b1;
    c_in = 1'b1;
    sum = '0;
    ofs_n = ofs;
    for (int d = DIM-1; d >= 0; d--) begin
      c_in = carry;
      sum = {1'b0, ofs[d*BW +: BW]} + {1'b0, shp[d*BW +: BW]};
      carry = c_in & (sum >= {1'b0, bnd[d*BW +: BW]});
      ofs_n[d*BW +: BW] = !c_in ? ofs[d*BW +: BW] : carry ? '0 : sum[BW-1:0];
    end
  end
  always_comb begin
    cfg_ack = cfg_rdy & (state == IDLE) & ~i_rst;
    dst_bofs_rdy = (state == BUSY);
    state_n = (state == IDLE) ? ((cfg_ack && !zero_bnd) ? BUSY : IDLE)
                              : ((dst_bofs_ack && carry) ? IDLE : BUSY);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      ofs <= '0;
      bnd <= '0;
      shp <= '0;
    end else begin
      state <= state_n;
      if (cfg_ack) begin
        bnd <= i_bboundary;
        shp <= shp_in;
        ofs <= '0;
      end else if (dst_bofs_rdy && dst_bofs_ack) begin
        ofs <= ofs_n;
      end
    end
  end
  assign o_bofs = ofs;
`ifdef BOFS_ISLAST_EN
  assign o_islast = dst_bofs_rdy & carry;
`endif
endmodule
